pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, flush, and NOP bubble output. It is the successor to the fixed-width stall/flush stage registers between the IF/ID/EX/MEM/WB stages of the 5-stage MIPS core. It carries an arbitrary control/data payload plus the instruction word, sustains one transfer per cycle under backpressure, and reports occupancy and stall statistics for performance debug.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_slot.sv | 59 +++++
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants and helpers for the pipeline-stage
//                registers of the 5-stage core.
//  Revision    : 1.0  initial release
// ============================================================================
//  Contents
//    NOP_INST_DEFAULT : instruction shown by a stage that holds no transfer
//    OCC_W            : width of a two-slot stage occupancy count
//    occ_count()      : number of valid slots (0..2)
// ============================================================================
package pipe_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0020;
  localparam int unsigned OCC_W            = 2;

  function automatic logic [OCC_W-1:0] occ_count(input logic a_valid,
                                                 input logic b_valid);
    return {1'b0, a_valid} + {1'b0, b_valid};
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One storage entry of a pipeline stage: a valid bit plus a
//                payload and an instruction word, with load and clear.
//  Revision    : 1.0  initial release
// ============================================================================
//  Ports
//    clk        in   clock, rising edge
//    rst        in   asynchronous active-high reset
//    i_load     in   capture i_payload/i_inst and mark the slot valid
//    i_clear    in   mark the slot invalid (wins over i_load)
//    i_payload  in   payload to capture
//    i_inst     in   instruction to capture
//    o_valid    out  slot holds an entry
//    o_payload  out  stored payload (stale when o_valid=0)
//    o_inst     out  stored instruction (stale when o_valid=0)
// ============================================================================
module pipe_slot #(
  parameter int PAYLOAD_W = 54,
  parameter int INST_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic [INST_W-1:0]    i_inst,
  output logic                 o_valid,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic [INST_W-1:0]    o_inst
);

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [INST_W-1:0]    r_inst;

  // Clearing only drops the valid bit; the data register keeps its old value
  // because consumers mask the outputs with o_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_inst    <= '0;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
      r_inst    <= i_inst;
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;
  assign o_inst    = r_inst;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Pipeline-stage register with valid/ready handshake, a
//                two-entry (main + skid) buffer, flush, NOP bubble output
//                and a saturating stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
//  Ports
//    clk          in   clock, rising edge
//    rst          in   asynchronous active-high reset
//    in_valid     in   upstream has a transfer
//    in_ready     out  stage can accept (decoded from the skid valid bit)
//    in_payload   in   upstream payload
//    in_inst      in   upstream instruction
//    flush        in   kill all held entries and any same-cycle input
//    out_valid    out  stage holds a transfer
//    out_ready    in   downstream accepts
//    out_payload  out  head payload, zero when out_valid=0
//    out_inst     out  head instruction, NOP_INST when out_valid=0
//    occupancy    out  number of held entries (0..2)
//    stall_cnt    out  cycles with out_valid & !out_ready, saturating
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                PAYLOAD_W = 54,
  parameter int                INST_W    = 32,
  parameter logic [INST_W-1:0] NOP_INST  = INST_W'(NOP_INST_DEFAULT),
  parameter int                CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [INST_W-1:0]    in_inst,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [INST_W-1:0]    out_inst,
  output logic [OCC_W-1:0]     occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  // Slot state
  logic                 w_main_valid;
  logic [PAYLOAD_W-1:0] w_main_payload;
  logic [INST_W-1:0]    w_main_inst;
  logic                 w_skid_valid;
  logic [PAYLOAD_W-1:0] w_skid_payload;
  logic [INST_W-1:0]    w_skid_inst;

  // Steering
  logic                 w_accept;
  logic                 w_drain;
  logic                 w_main_free;
  logic                 w_main_load;
  logic                 w_main_clear;
  logic [PAYLOAD_W-1:0] w_main_d_payload;
  logic [INST_W-1:0]    w_main_d_inst;
  logic                 w_skid_load;
  logic                 w_skid_clear;

  logic [CNT_W-1:0]     r_stall_cnt;

  assign w_accept = in_valid & in_ready & ~flush;
  assign w_drain  = w_main_valid & out_ready;

  // Main can take a new entry this cycle when it is empty or being drained.
  assign w_main_free = ~w_main_valid | w_drain;

  // The skid entry is always older than the incoming transfer, so it refills
  // main first; the incoming transfer only goes to main when skid is empty.
  assign w_main_load      = w_main_free & (w_skid_valid | w_accept);
  assign w_main_clear     = flush | (w_main_free & ~w_skid_valid & ~w_accept);
  assign w_main_d_payload = w_skid_valid ? w_skid_payload : in_payload;
  assign w_main_d_inst    = w_skid_valid ? w_skid_inst    : in_inst;

  // Skid captures input when main stays occupied, or when main is refilled
  // from skid in the same cycle as an accept.
  assign w_skid_load  = w_accept & (~w_main_free | w_skid_valid);
  assign w_skid_clear = flush | (w_main_free & w_skid_valid & ~w_accept);

  pipe_slot #(
    .PAYLOAD_W (PAYLOAD_W),
    .INST_W    (INST_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_main_load),
    .i_clear   (w_main_clear),
    .i_payload (w_main_d_payload),
    .i_inst    (w_main_d_inst),
    .o_valid   (w_main_valid),
    .o_payload (w_main_payload),
    .o_inst    (w_main_inst)
  );

  pipe_slot #(
    .PAYLOAD_W (PAYLOAD_W),
    .INST_W    (INST_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_skid_load),
    .i_clear   (w_skid_clear),
    .i_payload (in_payload),
    .i_inst    (in_inst),
    .o_valid   (w_skid_valid),
    .o_payload (w_skid_payload),
    .o_inst    (w_skid_inst)
  );

  // Stall counter: saturates, ignores flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Outputs are decoded from registered state only.
  assign in_ready    = ~w_skid_valid;
  assign out_valid   = w_main_valid;
  assign out_payload = w_main_valid ? w_main_payload : '0;
  assign out_inst    = w_main_valid ? w_main_inst    : NOP_INST;
  assign occupancy   = occ_count(w_main_valid, w_skid_valid);
  assign stall_cnt   = r_stall_cnt;

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Scoreboard bench for pipe_stage_skid (CNT_W=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

  localparam int PW = 54;
  localparam int IW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [IW-1:0] in_inst;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [IW-1:0] out_inst;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .PAYLOAD_W (PW),
    .INST_W    (IW),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_inst     (in_inst),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_inst    (out_inst),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt)
  );

  typedef struct packed {
    logic [PW-1:0] p;
    logic [IW-1:0] i;
  } item_t;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;
  bit    streaming = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed output handshake and
  // checks the bubble encoding whenever the stage is empty.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", {10'd0, out_payload}, 64'hDEAD);
          end else begin
            item_t e;
            e = sb.pop_front();
            chk("out_payload", {10'd0, out_payload}, {10'd0, e.p});
            chk("out_inst", {32'd0, out_inst}, {32'd0, e.i});
          end
        end
      end else begin
        chk("bubble_inst", {32'd0, out_inst}, 64'h20);
        chk("bubble_payload", {10'd0, out_payload}, 64'd0);
      end
      if (streaming) begin
        chk("stream_nogap", {63'd0, out_valid}, 64'd1);
        chk("stream_occ_le1", {63'd0, (occupancy <= 2'd1)}, 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_valid to be taken; the expected output is queued at the
  // cycle the handshake is seen. Returns the number of refused cycles.
  task automatic wait_acc(input logic [PW-1:0] p, input logic [IW-1:0] i,
                          output int waits);
    bit    done;
    item_t it;
    done  = 1'b0;
    waits = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        it.p = p;
        it.i = i;
        sb.push_back(it);
        done = 1'b1;
      end else if (waits == 20) begin
        chk("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [PW-1:0] p, input logic [IW-1:0] i, output int waits);
    in_valid   = 1'b1;
    in_payload = p;
    in_inst    = i;
    wait_acc(p, i, waits);
  endtask

  initial begin
    int w;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_payload = '0;
    in_inst    = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'h20);
    chk("rst_occ", {62'd0, occupancy}, 64'd0);
    chk("rst_stall", {60'd0, stall_cnt}, 64'd0);
    @(posedge clk);
    #1;

    // Streaming: 8 back-to-back transfers, first accept on the first edge
    // after reset release.
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send(PW'(k), 32'h2000_0000 + k, w);
      chk("stream_wait", 64'(w), 64'd0);
      if (k == 1) streaming = 1'b1;
    end
    @(negedge clk);
    #1;
    streaming = 1'b0;
    repeat (2) tick();

    // Backpressure: A and B taken, C held upstream.
    out_ready = 1'b0;
    send(PW'(54'h0A), 32'h8C00_000A, w);
    send(PW'(54'h0B), 32'h8C00_000B, w);
    in_valid   = 1'b1;
    in_payload = PW'(54'h0C);
    in_inst    = 32'h8C00_000C;
    @(negedge clk);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_occ", {62'd0, occupancy}, 64'd2);
    chk("bp_head", {10'd0, out_payload}, 64'h0A);
    tick();
    out_ready = 1'b1;
    wait_acc(PW'(54'h0C), 32'h8C00_000C, w);
    chk("bp_c_one_cycle_after_ready", 64'(w), 64'd1);
    repeat (3) tick();
    chk("bp_drained_sb", 64'(sb.size()), 64'd0);
    chk("bp_drained_occ", {62'd0, occupancy}, 64'd0);

    // Simultaneous drain and accept: occupancy unchanged, head advances.
    out_ready = 1'b0;
    send(PW'(54'h111), 32'h0111_0000, w);
    out_ready = 1'b1;
    send(PW'(54'h222), 32'h0222_0000, w);
    out_ready = 1'b0;
    @(negedge clk);
    chk("sim_occ", {62'd0, occupancy}, 64'd1);
    chk("sim_head", {10'd0, out_payload}, 64'h222);
    tick();
    out_ready = 1'b1;
    repeat (2) tick();

    // Flush with full skid and a same-cycle input D.
    out_ready = 1'b0;
    send(PW'(54'h31), 32'h0000_0031, w);
    send(PW'(54'h32), 32'h0000_0032, w);
    in_valid   = 1'b1;
    in_payload = PW'(54'hDD);
    in_inst    = 32'h0000_00DD;
    flush      = 1'b1;
    @(negedge clk);
    chk("fl_occ_before", {62'd0, occupancy}, 64'd2);
    sb.delete();
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_out_inst", {32'd0, out_inst}, 64'h20);
    chk("fl_occ", {62'd0, occupancy}, 64'd0);
    tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset mid-clock with two entries held.
    out_ready = 1'b0;
    send(PW'(54'h41), 32'h0000_0041, w);
    send(PW'(54'h42), 32'h0000_0042, w);
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_payload", {10'd0, out_payload}, 64'd0);
    chk("arst_out_inst", {32'd0, out_inst}, 64'h20);
    chk("arst_occ", {62'd0, occupancy}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_stall", {60'd0, stall_cnt}, 64'd0);
    tick();

    // Stall counter counts, saturates at 15, and survives flush.
    rst = 1'b0;
    send(PW'(54'h51), 32'h0000_0051, w);
    chk("st_first_accept", 64'(w), 64'd0);
    chk("st_start", {60'd0, stall_cnt}, 64'd0);
    repeat (5) tick();
    chk("st_count5", {60'd0, stall_cnt}, 64'd5);
    repeat (15) tick();
    chk("st_sat", {60'd0, stall_cnt}, 64'd15);
    repeat (3) tick();
    chk("st_hold", {60'd0, stall_cnt}, 64'd15);
    flush = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0;
    chk("st_after_flush", {60'd0, stall_cnt}, 64'd15);
    chk("st_flush_empty", {63'd0, out_valid}, 64'd0);

    out_ready = 1'b1;
    repeat (3) tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_stage_skid
`default_nettype wire
